d_stream_checker: RTL and testbench
===================================

// Module: d_stream_checker
// PURPOSE
//   Receive-side checker for the enable-gated serial bit stream driven into D_flip_flop (D, ENA).
//   Samples D on enabled clock edges, locks onto the alternating 0/1 pattern, then flags and counts
//   deviations. Gives on-board pass/fail for the flip-flop lab without a waveform viewer.
// PARAMETERS
//   LOCK_LEN  4   consecutive alternating samples required to declare lock (2..15)
//   CNT_W     8   width of ERR_CNT and BIT_CNT (saturating counters)
// PORTS
//   CLK      in   1      system clock, rising-edge
//   RSTN     in   1      asynchronous reset, active-low
//   D        in   1      serial data bit under check
//   ENA      in   1      sample qualifier; D is sampled only on edges where ENA=1
//   CLR      in   1      synchronous clear of ERR_CNT and BIT_CNT (state untouched)
//   LOCKED   out  1      1 while FSM is in LOCK
//   ERR      out  1      one-cycle pulse per mismatching sample while locked
//   ERR_CNT  out  CNT_W  mismatches seen while locked, saturates at all-ones
//   BIT_CNT  out  CNT_W  samples taken while locked, saturates at all-ones
// BEHAVIOUR
//   Reset (RSTN=0, async): state=HUNT, last=0, run=0, miss=0; LOCKED=0, ERR=0, ERR_CNT=0, BIT_CNT=0.
//   All outputs registered; effect of a sample visible 1 cycle after the sampling edge.
//   Edge with ENA=0: no sample; state, last, run, miss, counters hold; ERR=0.
//   FSM (sample = edge with ENA=1):
//     HUNT : last<=D, run<=1 -> SYNC.
//     SYNC : D!=last -> last<=D, run<=run+1; if run+1==LOCK_LEN -> LOCK (miss<=0).
//            D==last -> last<=D, run<=1, stay SYNC.
//     LOCK : expected = ~last. Always last<=expected (flywheel; a bad bit does not re-phase).
//            match    -> miss<=0, BIT_CNT++.
//            mismatch -> ERR=1 next cycle, ERR_CNT++, BIT_CNT++, miss<=miss+1;
//                        second consecutive mismatch -> HUNT (LOCKED=0 next cycle), run<=0.
//   LOCKED = (state==LOCK), registered with state.
//   ERR_CNT/BIT_CNT: increment only in LOCK; saturate at 2^CNT_W-1, never wrap.
//   CLR=1: both counters <=0 that edge; CLR beats a same-edge increment (result 0);
//     ERR pulse still asserted for a same-edge mismatch; FSM unaffected.
//   Lock-loss edge (2nd mismatch): that mismatch is counted in ERR_CNT and BIT_CNT, ERR pulses.
//   RSTN asserted mid-stream: immediate return to reset values regardless of state/ENA.
//   Exactly LOCK_LEN alternating samples from HUNT give LOCKED=1 one cycle after the LOCK_LEN-th.
// TESTING
//   1 Reset: RSTN=0 with D/ENA toggling -> all outputs 0; release, ENA=0 for 5 edges -> state holds HUNT.
//   2 Lock: LOCK_LEN=4, ENA=1, D=0,1,0,1 -> LOCKED=1 after 4th sample; D=0,1,0,1 more -> BIT_CNT=4, ERR_CNT=0.
//   3 Single error: locked, expected 0 but D=1 -> ERR pulse 1 cycle, ERR_CNT=1, LOCKED stays 1;
//     next D=1 (flywheel expects 1) -> no error, miss cleared.
//   4 Lock loss: locked, two consecutive wrong bits -> ERR pulses twice, ERR_CNT=2, LOCKED=0; then
//     D=1,1,0,1,0 -> relock after 4 alternations (1,0,1,0 tail).
//   5 ENA gating: locked, pattern interleaved with ENA=0 edges where D held wrong -> no ERR, BIT_CNT counts ENA edges only.
//   6 Saturation/CLR: CNT_W=3, 10 mismatches spaced by matches -> ERR_CNT=7 holds; CLR with same-edge
//     mismatch -> ERR=1, ERR_CNT=0, BIT_CNT=0.

Source files
------------

// File: rtl/d_stream_checker.sv
// rtl/d_stream_checker.sv - alternating-pattern lock and error checker for an enable-gated serial bit stream
module d_stream_checker #(
    parameter int LOCK_LEN = 4,
    parameter int CNT_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_d,
    input  logic             i_ena,
    input  logic             i_clr,
    output logic             o_locked,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_bit_cnt
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_LEN_W = 4'(LOCK_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           r_state;
    logic             r_last;
    logic [3:0]       r_run;
    logic             r_miss;
    logic             r_locked;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_bit_cnt;

    logic       w_lock_sample;
    logic       w_mismatch;
    logic [3:0] w_run_nxt;

    assign w_lock_sample = i_ena && (r_state == LOCK);
    // In LOCK the expected bit is always the complement of the flywheel phase.
    assign w_mismatch    = (i_d == r_last);
    assign w_run_nxt     = r_run + 4'd1;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= HUNT;
            r_last    <= 1'b0;
            r_run     <= 4'd0;
            r_miss    <= 1'b0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_err <= 1'b0;

            // Clear wins over any increment on the same edge; counters saturate.
            if (i_clr) begin
                r_err_cnt <= '0;
                r_bit_cnt <= '0;
            end else if (w_lock_sample) begin
                if (r_bit_cnt != CNT_MAX) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                if (w_mismatch && (r_err_cnt != CNT_MAX)) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end

            if (i_ena) begin
                case (r_state)
                    HUNT: begin
                        r_last   <= i_d;
                        r_run    <= 4'd1;
                        r_state  <= SYNC;
                        r_locked <= 1'b0;
                    end
                    SYNC: begin
                        r_last <= i_d;
                        if (i_d != r_last) begin
                            r_run <= w_run_nxt;
                            if (w_run_nxt == LOCK_LEN_W) begin
                                r_state  <= LOCK;
                                r_locked <= 1'b1;
                                r_miss   <= 1'b0;
                            end
                        end else begin
                            r_run <= 4'd1;
                        end
                    end
                    LOCK: begin
                        r_last <= ~r_last;
                        if (!w_mismatch) begin
                            r_miss <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                            if (r_miss) begin
                                r_state  <= HUNT;
                                r_locked <= 1'b0;
                                r_run    <= 4'd0;
                                r_miss   <= 1'b0;
                            end else begin
                                r_miss <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                        r_run    <= 4'd0;
                        r_miss   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_locked  = r_locked;
    assign o_err     = r_err;
    assign o_err_cnt = r_err_cnt;
    assign o_bit_cnt = r_bit_cnt;

endmodule

// File: tb/tb_d_stream_checker.sv
// tb/tb_d_stream_checker.sv - directed bench for d_stream_checker (CNT_W=8 and CNT_W=3 instances)
module tb_d_stream_checker;

    logic       clk = 1'b0;
    logic       rstn;
    logic       d;
    logic       ena;
    logic       clr;
    logic       locked_a, err_a;
    logic [7:0] err_cnt_a, bit_cnt_a;
    logic       locked_b, err_b;
    logic [2:0] err_cnt_b, bit_cnt_b;

    logic [17:0] obs_a, exp_a;
    logic [7:0]  obs_b, exp_b;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    d_stream_checker #(.LOCK_LEN(4), .CNT_W(8)) dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_d(d), .i_ena(ena), .i_clr(clr),
        .o_locked(locked_a), .o_err(err_a), .o_err_cnt(err_cnt_a), .o_bit_cnt(bit_cnt_a)
    );

    d_stream_checker #(.LOCK_LEN(4), .CNT_W(3)) dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_d(d), .i_ena(ena), .i_clr(clr),
        .o_locked(locked_b), .o_err(err_b), .o_err_cnt(err_cnt_b), .o_bit_cnt(bit_cnt_b)
    );

    assign obs_a = {locked_a, err_a, err_cnt_a, bit_cnt_a};
    assign obs_b = {locked_b, err_b, err_cnt_b, bit_cnt_b};

    // Apply inputs, take one rising edge, settle 1ns past it.
    task automatic step(input logic sd, input logic sena, input logic sclr);
        d   = sd;
        ena = sena;
        clr = sclr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        for (int i = 0; i < 4; i++) step(i[0], ~i[0], 1'b0);
        exp_a = 18'h0;
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL reset_a got=%h exp=%h", obs_a, exp_a); end
        exp_b = 8'h0;
        n_vec++;
        if (obs_b !== exp_b) begin n_miss++; $display("FAIL reset_b got=%h exp=%h", obs_b, exp_b); end
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) step(i[0], 1'b0, 1'b0);
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL ena0_hold got=%h exp=%h", obs_a, exp_a); end
    endtask

    task automatic test_lock;
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        exp_a = {1'b0, 1'b0, 8'd0, 8'd0};
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL lock_3rd got=%h exp=%h", obs_a, exp_a); end
        step(1'b1, 1'b1, 1'b0);
        exp_a = {1'b1, 1'b0, 8'd0, 8'd0};
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL lock_4th got=%h exp=%h", obs_a, exp_a); end
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        exp_a = {1'b1, 1'b0, 8'd0, 8'd4};
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL lock_count got=%h exp=%h", obs_a, exp_a); end
    endtask

    task automatic test_single_error;
        step(1'b1, 1'b1, 1'b0);
        exp_a = {1'b1, 1'b1, 8'd1, 8'd5};
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL err1_pulse got=%h exp=%h", obs_a, exp_a); end
        step(1'b1, 1'b1, 1'b0);
        exp_a = {1'b1, 1'b0, 8'd1, 8'd6};
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL err1_flywheel got=%h exp=%h", obs_a, exp_a); end
        step(1'b1, 1'b1, 1'b0);
        exp_a = {1'b1, 1'b1, 8'd2, 8'd7};
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL err1_miss_cleared got=%h exp=%h", obs_a, exp_a); end
        step(1'b1, 1'b1, 1'b0);
        exp_a = {1'b1, 1'b0, 8'd2, 8'd8};
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL err1_recover got=%h exp=%h", obs_a, exp_a); end
    endtask

    task automatic test_lock_loss;
        step(1'b0, 1'b0, 1'b1);
        exp_a = {1'b1, 1'b0, 8'd0, 8'd0};
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL loss_clr got=%h exp=%h", obs_a, exp_a); end
        step(1'b1, 1'b1, 1'b0);
        exp_a = {1'b1, 1'b1, 8'd1, 8'd1};
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL loss_first got=%h exp=%h", obs_a, exp_a); end
        step(1'b0, 1'b1, 1'b0);
        exp_a = {1'b0, 1'b1, 8'd2, 8'd2};
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL loss_second got=%h exp=%h", obs_a, exp_a); end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        exp_a = {1'b0, 1'b0, 8'd2, 8'd2};
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL relock_early got=%h exp=%h", obs_a, exp_a); end
        step(1'b0, 1'b1, 1'b0);
        exp_a = {1'b1, 1'b0, 8'd2, 8'd2};
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL relock got=%h exp=%h", obs_a, exp_a); end
    endtask

    task automatic test_ena_gating;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        exp_a = {1'b1, 1'b0, 8'd0, 8'd1};
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL gate_hold1 got=%h exp=%h", obs_a, exp_a); end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        exp_a = {1'b1, 1'b0, 8'd0, 8'd2};
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL gate_hold2 got=%h exp=%h", obs_a, exp_a); end
        step(1'b1, 1'b1, 1'b0);
        exp_a = {1'b1, 1'b0, 8'd0, 8'd3};
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL gate_count got=%h exp=%h", obs_a, exp_a); end
    endtask

    task automatic test_saturation_clr;
        step(1'b0, 1'b0, 1'b1);
        // Expected is 0 here; constant D=1 alternates mismatch/match.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);
        exp_b = {1'b1, 1'b0, 3'd7, 3'd7};
        n_vec++;
        if (obs_b !== exp_b) begin n_miss++; $display("FAIL sat_b got=%h exp=%h", obs_b, exp_b); end
        exp_a = {1'b1, 1'b0, 8'd10, 8'd20};
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL sat_a got=%h exp=%h", obs_a, exp_a); end
        step(1'b1, 1'b1, 1'b1);
        exp_b = {1'b1, 1'b1, 3'd0, 3'd0};
        n_vec++;
        if (obs_b !== exp_b) begin n_miss++; $display("FAIL clr_mismatch_b got=%h exp=%h", obs_b, exp_b); end
        exp_a = {1'b1, 1'b1, 8'd0, 8'd0};
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL clr_mismatch_a got=%h exp=%h", obs_a, exp_a); end
    endtask

    task automatic test_async_reset;
        step(1'b1, 1'b1, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        exp_a = 18'h0;
        n_vec++;
        if (obs_a !== exp_a) begin n_miss++; $display("FAIL async_reset got=%h exp=%h", obs_a, exp_a); end
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        d    = 1'b0;
        ena  = 1'b0;
        clr  = 1'b0;
        test_reset();
        test_lock();
        test_single_error();
        test_lock_loss();
        test_ena_gating();
        test_saturation_clr();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
